demux_de_control: RTL and testbench
===================================

Name: demux_de_control

Overview:
- Receive-side counterpart of the transmit control/data mux.
- Takes the byte stream of a lane plus a K-flag (from the 8b/10b decoder) and classifies every symbol into the same 4-bit CONTROL code space used on transmit.
- Strips ordered-set and filler symbols and deframes STP/SDP ... END/EDB packets into a data-byte stream with start/end/bad strobes and a byte count.
- Sits between the lane decoder and the RX buffer / link layer.

Parameters:
- MAX_LEN, 255: maximum payload bytes per packet. Range 1..255.
- DLLP_LEN, 6: required payload byte count of an SDP-framed packet.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RESET  input  1  synchronous, active-high reset.
- VALID_IN  input  1  IN/IN_K carry a symbol this cycle.
- IN  input  8  received byte.
- IN_K  input  1  1 = IN is a control (K) symbol; 0 = data byte.
- CONTROL  output  4  code of the last accepted symbol; 15 = unknown K.
- DATA_OUT  output  8  payload byte.
- DATA_VALID  output  1  DATA_OUT is a payload byte (1-cycle pulse per byte).
- PKT_START  output  1  1-cycle pulse on an accepted STP/SDP.
- PKT_TYPE  output  1  0 = TLP (STP), 1 = DLLP (SDP); updated at PKT_START, held otherwise.
- PKT_END  output  1  1-cycle pulse when a packet closes, normally or by abort.
- PKT_BAD  output  1  qualifies PKT_END: 1 = EDB, abort, or length error.
- LEN  output  8  payload bytes of the closed packet; valid with PKT_END.
- ERROR  output  1  1-cycle pulse on any framing or symbol error.

Behaviour:
- All outputs are registered, with 1-cycle latency from the input sample.
- Reset values:
  - CONTROL = 8 (IDL); PKT_TYPE = 0; LEN = 0; DATA_OUT = 0.
  - All strobes (DATA_VALID, PKT_START, PKT_END, PKT_BAD, ERROR) = 0.
  - FSM = IDLE; byte counter = 0.
- RESET mid-packet: the packet is dropped silently, with no PKT_END and no ERROR.
- VALID_IN = 0: no state or counter change; all strobes 0; CONTROL, DATA_OUT, PKT_TYPE and LEN hold.
- CONTROL decode when IN_K = 1:
  - BC→0 (COM), F7→1 (PAD), 1C→2 (SKP), FB→3 (STP), 5C→4 (SDP).
  - FD→5 (END), FE→6 (EDB), 3C→7 (FTS), 7C→8 (IDL).
  - Any other byte → 15 plus an ERROR pulse.
- CONTROL = 9 when IN_K = 0.
- Counter: 8 bits, reset to 0 on every packet start; never wraps (see overflow).
- FSM states: IDLE, TLP, DLLP.
- IDLE:
  - STP → TLP, PKT_START = 1, PKT_TYPE = 0.
  - SDP → DLLP, PKT_START = 1, PKT_TYPE = 1.
  - COM/PAD/SKP/FTS/IDL: no action.
  - Data byte → ERROR, byte discarded (DATA_VALID = 0).
  - END/EDB/unknown K → ERROR, stay in IDLE.
- TLP/DLLP:
  - Data byte with count < MAX_LEN → DATA_OUT = IN, DATA_VALID = 1, count+1.
  - Data byte with count == MAX_LEN → byte discarded, ERROR, PKT_END, PKT_BAD = 1, LEN = MAX_LEN, go to IDLE.
  - SKP → removed transparently; state and count unchanged.
  - END → PKT_END, LEN = count, go to IDLE. PKT_BAD = 1 if count == 0, or if in DLLP and count != DLLP_LEN; otherwise 0.
  - EDB → PKT_END, PKT_BAD = 1, LEN = count, go to IDLE; no ERROR pulse.
  - STP/SDP (nested start) → old packet closes with PKT_END, PKT_BAD = 1, ERROR, LEN = count. In the same cycle PKT_START = 1 for the new packet, PKT_TYPE is updated, count = 0, and the FSM enters TLP/DLLP per the symbol.
  - COM/PAD/FTS/IDL/unknown K → PKT_END, PKT_BAD = 1, ERROR, LEN = count, go to IDLE.
- PKT_BAD and LEN change only with PKT_END; PKT_BAD = 0 whenever PKT_END = 0.

Test Plan:
- Clean TLP: symbols STP, 8'h11, 8'h22, 8'h33, END (K as appropriate) → PKT_START at the STP output cycle; DATA_VALID ×3 with 11/22/33; PKT_END, PKT_BAD = 0, LEN = 3, PKT_TYPE = 0; CONTROL sequence 3, 9, 9, 9, 5.
- DLLP length check: SDP + 6 data + END → PKT_BAD = 0, LEN = 6, PKT_TYPE = 1. SDP + 5 data + END → PKT_BAD = 1, LEN = 5, no ERROR.
- Transparency: STP, A0, SKP, VALID_IN = 0 for 2 cycles, A1, END → exactly 2 DATA_VALID pulses (A0, A1); LEN = 2; CONTROL = 2 after SKP and holds while VALID_IN = 0.
- Errors:
  - Data 8'h55 in IDLE → ERROR, no DATA_VALID.
  - STP, 01, SDP → PKT_END + PKT_BAD + ERROR, LEN = 1 and PKT_START with PKT_TYPE = 1 in the same cycle.
  - K byte 8'h00 → CONTROL = 15, ERROR.
- Overflow with MAX_LEN = 4: STP + 5 data → 4 DATA_VALID pulses; on the 5th byte ERROR, PKT_END, PKT_BAD = 1, LEN = 4; a following END → ERROR only (FSM is in IDLE).
- Reset mid-packet: STP, 2 data, RESET for 1 cycle, then END → no PKT_END at any point; END → ERROR; outputs match reset values during the cycle after RESET.

Source files
------------

// File: rtl/demux_de_control.sv
// Receive-side control/data demux: classifies decoded lane symbols into control codes
// and deframes STP/SDP ... END/EDB packets into a payload byte stream with framing strobes.
module demux_de_control #(
    parameter int MAX_LEN  = 255,
    parameter int DLLP_LEN = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VALID_IN,
    input  logic [7:0] IN,
    input  logic       IN_K,
    output logic [3:0] CONTROL,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       PKT_START,
    output logic       PKT_TYPE,
    output logic       PKT_END,
    output logic       PKT_BAD,
    output logic [7:0] LEN,
    output logic       ERROR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TLP  = 2'd1;
    localparam logic [1:0] ST_DLLP = 2'd2;

    localparam logic [3:0] C_SKP  = 4'd2;
    localparam logic [3:0] C_STP  = 4'd3;
    localparam logic [3:0] C_SDP  = 4'd4;
    localparam logic [3:0] C_END  = 4'd5;
    localparam logic [3:0] C_EDB  = 4'd6;
    localparam logic [3:0] C_IDL  = 4'd8;
    localparam logic [3:0] C_DATA = 4'd9;
    localparam logic [3:0] C_UNK  = 4'd15;

    localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [7:0] DLLP_LEN_B = 8'(DLLP_LEN);

    // Table index is the control code of the K symbol
    localparam logic [7:0] K_TABLE [9] = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C,
                                           8'hFD, 8'hFE, 8'h3C, 8'h7C};

    logic [8:0] k_hit;
    logic [3:0] k_code;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_kdec
            assign k_hit[gi] = (IN == K_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        k_code = C_UNK;
        for (int i = 0; i < 9; i++) begin
            if (k_hit[i]) k_code = 4'(i);
        end
    end

    logic [1:0] state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic [3:0] control_reg, control_next;
    logic [7:0] data_reg, data_next;
    logic       dv_reg, dv_next;
    logic       start_reg, start_next;
    logic       type_reg, type_next;
    logic       pkt_end_reg, pkt_end_next;
    logic       bad_reg, bad_next;
    logic [7:0] len_reg, len_next;
    logic       err_reg, err_next;
    logic       in_pkt;

    assign in_pkt = (state_reg != ST_IDLE);

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        control_next = control_reg;
        data_next    = data_reg;
        type_next    = type_reg;
        len_next     = len_reg;
        dv_next      = 1'b0;
        start_next   = 1'b0;
        pkt_end_next = 1'b0;
        bad_next     = 1'b0;
        err_next     = 1'b0;

        if (VALID_IN) begin
            if (!IN_K) begin
                control_next = C_DATA;
                if (!in_pkt) begin
                    err_next = 1'b1;
                end else if (count_reg == MAX_LEN_B) begin
                    // Overflow byte is dropped and the packet is closed as bad
                    err_next     = 1'b1;
                    pkt_end_next = 1'b1;
                    bad_next     = 1'b1;
                    len_next     = MAX_LEN_B;
                    state_next   = ST_IDLE;
                end else begin
                    data_next  = IN;
                    dv_next    = 1'b1;
                    count_next = count_reg + 8'd1;
                end
            end else begin
                control_next = k_code;
                case (k_code)
                    C_STP, C_SDP: begin
                        if (in_pkt) begin
                            pkt_end_next = 1'b1;
                            bad_next     = 1'b1;
                            err_next     = 1'b1;
                            len_next     = count_reg;
                        end
                        start_next = 1'b1;
                        type_next  = (k_code == C_SDP);
                        count_next = 8'd0;
                        state_next = (k_code == C_SDP) ? ST_DLLP : ST_TLP;
                    end
                    C_SKP: begin
                    end
                    C_END: begin
                        if (!in_pkt) begin
                            err_next = 1'b1;
                        end else begin
                            pkt_end_next = 1'b1;
                            len_next     = count_reg;
                            bad_next     = (count_reg == 8'd0) ||
                                           (state_reg == ST_DLLP && count_reg != DLLP_LEN_B);
                            state_next   = ST_IDLE;
                        end
                    end
                    C_EDB: begin
                        if (!in_pkt) begin
                            err_next = 1'b1;
                        end else begin
                            pkt_end_next = 1'b1;
                            bad_next     = 1'b1;
                            len_next     = count_reg;
                            state_next   = ST_IDLE;
                        end
                    end
                    default: begin
                        // Fillers are harmless between packets but abort one in flight
                        if (k_code == C_UNK) err_next = 1'b1;
                        if (in_pkt) begin
                            pkt_end_next = 1'b1;
                            bad_next     = 1'b1;
                            err_next     = 1'b1;
                            len_next     = count_reg;
                            state_next   = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 8'd0;
            control_reg <= C_IDL;
            data_reg    <= 8'd0;
            dv_reg      <= 1'b0;
            start_reg   <= 1'b0;
            type_reg    <= 1'b0;
            pkt_end_reg <= 1'b0;
            bad_reg     <= 1'b0;
            len_reg     <= 8'd0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            control_reg <= control_next;
            data_reg    <= data_next;
            dv_reg      <= dv_next;
            start_reg   <= start_next;
            type_reg    <= type_next;
            pkt_end_reg <= pkt_end_next;
            bad_reg     <= bad_next;
            len_reg     <= len_next;
            err_reg     <= err_next;
        end
    end

    assign CONTROL    = control_reg;
    assign DATA_OUT   = data_reg;
    assign DATA_VALID = dv_reg;
    assign PKT_START  = start_reg;
    assign PKT_TYPE   = type_reg;
    assign PKT_END    = pkt_end_reg;
    assign PKT_BAD    = bad_reg;
    assign LEN        = len_reg;
    assign ERROR      = err_reg;

endmodule

// File: tb/tb_demux_de_control.sv
// Bench for demux_de_control: two instances (default and MAX_LEN=4) driven by the same
// directed and random symbol stream, each compared against a packet-level reference model.
module tb_demux_de_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, valid_in, in_k;
    logic [7:0] in_byte;

    logic [3:0] control_a, control_b;
    logic [7:0] data_out_a, data_out_b, len_a, len_b;
    logic       dv_a, dv_b, start_a, start_b, type_a, type_b;
    logic       end_a, end_b, bad_a, bad_b, err_a, err_b;

    demux_de_control dut_a (
        .CLK(clk), .RESET(reset), .VALID_IN(valid_in), .IN(in_byte), .IN_K(in_k),
        .CONTROL(control_a), .DATA_OUT(data_out_a), .DATA_VALID(dv_a),
        .PKT_START(start_a), .PKT_TYPE(type_a), .PKT_END(end_a), .PKT_BAD(bad_a),
        .LEN(len_a), .ERROR(err_a)
    );

    demux_de_control #(.MAX_LEN(4), .DLLP_LEN(6)) dut_b (
        .CLK(clk), .RESET(reset), .VALID_IN(valid_in), .IN(in_byte), .IN_K(in_k),
        .CONTROL(control_b), .DATA_OUT(data_out_b), .DATA_VALID(dv_b),
        .PKT_START(start_b), .PKT_TYPE(type_b), .PKT_END(end_b), .PKT_BAD(bad_b),
        .LEN(len_b), .ERROR(err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one packet context per instance
    int         max_len [2] = '{255, 4};
    bit         m_in_pkt [2];
    bit         m_dllp [2];
    int         m_cnt [2];
    logic [3:0] e_control [2];
    logic [7:0] e_data [2];
    logic [7:0] e_len [2];
    logic       e_dv [2], e_start [2], e_type [2], e_end [2], e_bad [2], e_err [2];

    function automatic logic [3:0] k_lookup(input logic [7:0] b);
        case (b)
            8'hBC: return 4'd0;
            8'hF7: return 4'd1;
            8'h1C: return 4'd2;
            8'hFB: return 4'd3;
            8'h5C: return 4'd4;
            8'hFD: return 4'd5;
            8'hFE: return 4'd6;
            8'h3C: return 4'd7;
            8'h7C: return 4'd8;
            default: return 4'd15;
        endcase
    endfunction

    task automatic close_pkt(input int m, input bit bad);
        e_end[m]    = 1'b1;
        e_bad[m]    = bad;
        e_len[m]    = 8'(m_cnt[m]);
        m_in_pkt[m] = 1'b0;
    endtask

    task automatic model_step(input int m, input bit rst, input bit v, input bit k,
                              input logic [7:0] b);
        e_dv[m] = 0; e_start[m] = 0; e_end[m] = 0; e_bad[m] = 0; e_err[m] = 0;
        if (rst) begin
            m_in_pkt[m] = 0; m_dllp[m] = 0; m_cnt[m] = 0;
            e_control[m] = 4'd8; e_data[m] = 8'd0; e_type[m] = 0; e_len[m] = 8'd0;
        end else if (v && !k) begin
            e_control[m] = 4'd9;
            if (!m_in_pkt[m]) begin
                e_err[m] = 1;
            end else if (m_cnt[m] >= max_len[m]) begin
                e_err[m] = 1;
                close_pkt(m, 1'b1);
            end else begin
                e_data[m] = b;
                e_dv[m]   = 1;
                m_cnt[m]++;
            end
        end else if (v) begin
            e_control[m] = k_lookup(b);
            if (b == 8'hFB || b == 8'h5C) begin
                if (m_in_pkt[m]) begin
                    e_err[m] = 1;
                    close_pkt(m, 1'b1);
                end
                e_start[m] = 1;
                e_type[m]  = (b == 8'h5C);
                m_dllp[m]  = (b == 8'h5C);
                m_in_pkt[m] = 1;
                m_cnt[m]   = 0;
            end else if (b == 8'h1C) begin
                // skip ordered-set symbol: invisible everywhere
            end else if (b == 8'hFD) begin
                if (!m_in_pkt[m]) e_err[m] = 1;
                else close_pkt(m, m_cnt[m] == 0 || (m_dllp[m] && m_cnt[m] != 6));
            end else if (b == 8'hFE) begin
                if (!m_in_pkt[m]) e_err[m] = 1;
                else close_pkt(m, 1'b1);
            end else begin
                if (k_lookup(b) == 4'd15) e_err[m] = 1;
                if (m_in_pkt[m]) begin
                    e_err[m] = 1;
                    close_pkt(m, 1'b1);
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit k, input logic [7:0] b);
        @(negedge clk);
        reset = rst; valid_in = v; in_k = k; in_byte = b;
        for (int m = 0; m < 2; m++) model_step(m, rst, v, k, b);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("d%0d.control", m), m == 0 ? control_a : control_b, e_control[m]);
            check_eq($sformatf("d%0d.data_out", m), m == 0 ? data_out_a : data_out_b, e_data[m]);
            check_eq($sformatf("d%0d.data_valid", m), m == 0 ? dv_a : dv_b, e_dv[m]);
            check_eq($sformatf("d%0d.pkt_start", m), m == 0 ? start_a : start_b, e_start[m]);
            check_eq($sformatf("d%0d.pkt_type", m), m == 0 ? type_a : type_b, e_type[m]);
            check_eq($sformatf("d%0d.pkt_end", m), m == 0 ? end_a : end_b, e_end[m]);
            check_eq($sformatf("d%0d.pkt_bad", m), m == 0 ? bad_a : bad_b, e_bad[m]);
            check_eq($sformatf("d%0d.len", m), m == 0 ? len_a : len_b, e_len[m]);
            check_eq($sformatf("d%0d.error", m), m == 0 ? err_a : err_b, e_err[m]);
        end
        $display("sym rst=%0b v=%0b k=%0b b=%02h | A ctl=%0d dv=%0b d=%02h st=%0b ty=%0b end=%0b bad=%0b len=%0d err=%0b | B end=%0b len=%0d err=%0b",
                 rst, v, k, b, control_a, dv_a, data_out_a, start_a, type_a, end_a, bad_a,
                 len_a, err_a, end_b, len_b, err_b);
    endtask

    task automatic ks(input logic [7:0] b);
        step(1'b0, 1'b1, 1'b1, b);
    endtask

    task automatic ds(input logic [7:0] b);
        step(1'b0, 1'b1, 1'b0, b);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] k_pool [9] = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h3C, 8'h7C};

    initial begin
        reset = 1'b1; valid_in = 1'b0; in_k = 1'b0; in_byte = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Clean TLP
        ks(8'hFB); ds(8'h11); ds(8'h22); ds(8'h33); ks(8'hFD);
        // DLLP correct and short length
        ks(8'h5C); for (int i = 0; i < 6; i++) ds(8'(8'hD0 + i)); ks(8'hFD);
        ks(8'h5C); for (int i = 0; i < 5; i++) ds(8'(8'hE0 + i)); ks(8'hFD);
        // SKP and VALID_IN gaps are transparent
        ks(8'hFB); ds(8'hA0); ks(8'h1C); gap(); gap(); ds(8'hA1); ks(8'hFD);
        // Errors: data in idle, nested start, unknown K, EDB, empty END
        ds(8'h55);
        ks(8'hFB); ds(8'h01); ks(8'h5C); ks(8'hFE);
        ks(8'h00);
        ks(8'hFB); ks(8'hFD);
        ks(8'hFB); ds(8'h02); ks(8'hBC); ks(8'hFD);
        // Overflow on the MAX_LEN=4 instance
        ks(8'hFB); for (int i = 0; i < 5; i++) ds(8'(8'h40 + i)); ks(8'hFD);
        // Reset mid-packet
        ks(8'hFB); ds(8'h61); ds(8'h62);
        step(1'b1, 1'b1, 1'b1, 8'hFD);
        ks(8'hFD);

        for (int n = 0; n < 1500; n++) begin
            bit         rst, v, k;
            logic [7:0] b;
            int         r;
            rst = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 7) != 0);
            k   = ($urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 11);
            if (!k)         b = 8'($urandom);
            else if (r < 9) b = k_pool[r];
            else if (r < 11) b = 8'hFD;
            else            b = 8'($urandom);
            step(rst, v, k, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
